// File: rtl/rd_label_pipe.sv
// Registered minicpu decode stage with security label tracking and a post-syscall stall.
// Optional feature RD_ILLEGAL_TRAP_EN: a retired illegal instruction sets a sticky trap that blocks intake.
module rd_label_pipe #(
  parameter int                 LABEL_W       = 2,
  parameter logic [LABEL_W-1:0] LABEL_RST     = '0,
  parameter int                 SYSCALL_STALL = 2
) (
  input  logic               CLK,
  input  logic               MRST_N,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_inst,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4:0]         RSaddr,
  output logic [4:0]         RTaddr,
  output logic [4:0]         RDaddr,
  output logic [31:0]        Imm,
  output logic               instIsSyscall,
  output logic               illegal,
  output logic               illegal_trap,
  output logic [LABEL_W-1:0] ReadLabel,
  output logic [LABEL_W-1:0] WriteLabel
);

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;

  assign op    = in_inst[31:26];
  assign rs    = in_inst[25:21];
  assign rt    = in_inst[20:16];
  assign rd    = in_inst[15:11];
  assign imm16 = in_inst[15:0];
  assign funct = in_inst[5:0];

  logic [4:0]  dec_rd;
  logic [31:0] dec_imm;
  logic        dec_sys, dec_ill, dec_setr_r, dec_setr_w, setr_hit;

  // SETR rides on the ADDI encoding with rs=0, rt selecting which labels to write.
  assign setr_hit = (in_inst[31:16] == 16'h2000 || in_inst[31:16] == 16'h2001 ||
                     in_inst[31:16] == 16'h2002) && (in_inst[15:LABEL_W] == '0);

  always_comb begin
    dec_rd     = 5'd0;
    dec_imm    = 32'd0;
    dec_sys    = 1'b0;
    dec_ill    = 1'b0;
    dec_setr_r = 1'b0;
    dec_setr_w = 1'b0;
    case (op)
      6'h00: begin
        case (funct)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
          6'h09, 6'h10, 6'h12,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B:                          dec_rd  = rd;
          6'h0C:                                 dec_sys = 1'b1;
          6'h08, 6'h0D, 6'h11, 6'h13,
          6'h18, 6'h19, 6'h1A, 6'h1B:            ;
          default:                               dec_ill = 1'b1;
        endcase
      end
      6'h01: begin
        if (!(rt == 5'h00 || rt == 5'h01 || rt == 5'h10 || rt == 5'h11))
          dec_ill = 1'b1;
      end
      6'h02, 6'h04, 6'h05, 6'h06, 6'h07: ;
      6'h03: dec_rd = 5'd31;
      6'h08, 6'h09, 6'h0A, 6'h0B: begin
        dec_rd  = rt;
        dec_imm = {{16{imm16[15]}}, imm16};
      end
      6'h0C, 6'h0D, 6'h0E: begin
        dec_rd  = rt;
        dec_imm = {16'd0, imm16};
      end
      6'h0F: begin
        dec_rd  = rt;
        dec_imm = {imm16, 16'd0};
      end
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26: begin
        dec_rd  = rt;
        dec_imm = {{16{imm16[15]}}, imm16};
      end
      6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E: dec_imm = {{16{imm16[15]}}, imm16};
      6'h11, 6'h31, 6'h39: ;
      default: dec_ill = 1'b1;
    endcase
    if (setr_hit) begin
      dec_rd     = 5'd0;
      dec_sys    = 1'b1;
      dec_setr_r = (in_inst[17:16] != 2'd2);
      dec_setr_w = (in_inst[17:16] != 2'd1);
    end
  end

  logic               vld_q, sys_q, ill_q, setr_r_q, setr_w_q;
  logic [4:0]         rs_q, rt_q, rd_q;
  logic [31:0]        imm_q;
  logic [LABEL_W-1:0] lbl_val_q;
  logic [LABEL_W-1:0] rlbl_q, rlbl_d, wlbl_q, wlbl_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               trap;
  logic               accept, retire;

  assign in_ready = (cnt_q == 4'd0) && (!vld_q || out_ready) && !trap;
  assign accept   = in_valid && in_ready;
  assign retire   = vld_q && out_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && dec_sys)   cnt_d = 4'(SYSCALL_STALL);
    else if (cnt_q != 4'd0)  cnt_d = cnt_q - 4'd1;
  end

  // Labels move only when the SETR leaves the stage, so anything decoded behind it sees the old value.
  always_comb begin
    rlbl_d = rlbl_q;
    wlbl_d = wlbl_q;
    if (retire && setr_r_q) rlbl_d = lbl_val_q;
    if (retire && setr_w_q) wlbl_d = lbl_val_q;
  end

  always_ff @(posedge CLK or negedge MRST_N) begin
    if (!MRST_N) begin
      vld_q     <= 1'b0;
      rs_q      <= 5'd0;
      rt_q      <= 5'd0;
      rd_q      <= 5'd0;
      imm_q     <= 32'd0;
      sys_q     <= 1'b0;
      ill_q     <= 1'b0;
      setr_r_q  <= 1'b0;
      setr_w_q  <= 1'b0;
      lbl_val_q <= '0;
      rlbl_q    <= LABEL_RST;
      wlbl_q    <= LABEL_RST;
      cnt_q     <= 4'd0;
    end else begin
      rlbl_q <= rlbl_d;
      wlbl_q <= wlbl_d;
      cnt_q  <= cnt_d;
      if (accept) begin
        vld_q     <= 1'b1;
        rs_q      <= rs;
        rt_q      <= rt;
        rd_q      <= dec_rd;
        imm_q     <= dec_imm;
        sys_q     <= dec_sys;
        ill_q     <= dec_ill;
        setr_r_q  <= dec_setr_r;
        setr_w_q  <= dec_setr_w;
        lbl_val_q <= in_inst[LABEL_W-1:0];
      end else if (retire) begin
        vld_q <= 1'b0;
      end
    end
  end

`ifdef RD_ILLEGAL_TRAP_EN
  logic trap_q;
  always_ff @(posedge CLK or negedge MRST_N) begin
    if (!MRST_N)               trap_q <= 1'b0;
    else if (retire && ill_q)  trap_q <= 1'b1;
  end
  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

  assign out_valid     = vld_q;
  assign RSaddr        = rs_q;
  assign RTaddr        = rt_q;
  assign RDaddr        = rd_q;
  assign Imm           = imm_q;
  assign instIsSyscall = sys_q;
  assign illegal       = ill_q;
  assign illegal_trap  = trap;
  assign ReadLabel     = rlbl_q;
  assign WriteLabel    = wlbl_q;

endmodule

// File: tb/tb_rd_label_pipe.sv
// Scoreboard bench for rd_label_pipe: expected bundles queued on accept, checked on retire.
module tb_rd_label_pipe;

  logic        CLK = 1'b0;
  logic        MRST_N;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, Imm;
  logic [4:0]  RSaddr, RTaddr, RDaddr;
  logic        instIsSyscall, illegal, illegal_trap;
  logic [1:0]  ReadLabel, WriteLabel;

  always #5 CLK = ~CLK;

  rd_label_pipe #(.LABEL_W(2), .LABEL_RST(2'b01), .SYSCALL_STALL(2)) dut (
    .CLK(CLK), .MRST_N(MRST_N),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready),
    .RSaddr(RSaddr), .RTaddr(RTaddr), .RDaddr(RDaddr), .Imm(Imm),
    .instIsSyscall(instIsSyscall), .illegal(illegal), .illegal_trap(illegal_trap),
    .ReadLabel(ReadLabel), .WriteLabel(WriteLabel)
  );

  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm;
    logic        sys, ill;
  } exp_t;

  exp_t q[$];
  int   tests_run = 0, tests_failed = 0;
  int   run = 0, max_run = 0;
  logic bp_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic send(input logic [31:0] inst, input logic [4:0] erd, input logic [31:0] eimm,
                      input logic esys, input logic eill);
    int   tries = 0;
    exp_t e;
    @(negedge CLK);
    in_valid = 1'b1;
    in_inst  = inst;
    if (bp_en) out_ready = 1'($urandom_range(0, 1));
    #1;
    while (!in_ready && tries < 60) begin
      @(negedge CLK);
      if (bp_en) out_ready = 1'($urandom_range(0, 1));
      #1;
      tries++;
    end
    if (!in_ready) begin
      chk("send_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
    end else begin
      e.rs = inst[25:21]; e.rt = inst[20:16]; e.rd = erd;
      e.imm = eimm; e.sys = esys; e.ill = eill;
      q.push_back(e);
      @(posedge CLK);
    end
  endtask

  task automatic idle(input int n);
    @(negedge CLK);
    in_valid = 1'b0;
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    in_valid = 1'b0;
    MRST_N   = 1'b0;
    #1;
    q.delete();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_rlabel", {30'd0, ReadLabel}, 32'd1);
    @(negedge CLK);
    MRST_N = 1'b1;
    #1;
  endtask

  // Output monitor: pop and compare on every retire, and check holding under backpressure.
  logic        prev_stall = 1'b0;
  logic [4:0]  prev_rd;
  logic [31:0] prev_imm;
  always begin
    exp_t e;
    @(negedge CLK);
    #2;
    if (MRST_N) begin
      if (out_valid) begin
        run++;
        if (run > max_run) max_run = run;
      end else run = 0;
      if (prev_stall && out_valid) begin
        chk("hold_rd", {27'd0, RDaddr}, {27'd0, prev_rd});
        chk("hold_imm", Imm, prev_imm);
      end
      prev_stall = out_valid && !out_ready;
      prev_rd    = RDaddr;
      prev_imm   = Imm;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_out", {31'd0, out_valid}, 32'd0);
        else begin
          e = q.pop_front();
          chk("rs",  {27'd0, RSaddr}, {27'd0, e.rs});
          chk("rt",  {27'd0, RTaddr}, {27'd0, e.rt});
          chk("rd",  {27'd0, RDaddr}, {27'd0, e.rd});
          chk("imm", Imm, e.imm);
          chk("sys", {31'd0, instIsSyscall}, {31'd0, e.sys});
          chk("ill", {31'd0, illegal}, {31'd0, e.ill});
        end
      end
    end else prev_stall = 1'b0;
  end

  logic [31:0] mx_inst [0:12] = '{32'h3C01ABCD, 32'h3442F0F0, 32'h8CA38000, 32'hACA38000,
                                  32'h0C000010, 32'h10220004, 32'h00031080, 32'h03E00008,
                                  32'h00004012, 32'hC4000000, 32'h2C65FFFE, 32'h0060F809,
                                  32'h30A4FFFF};
  logic [4:0]  mx_rd   [0:12] = '{5'd1, 5'd2, 5'd3, 5'd0, 5'd31, 5'd0, 5'd2, 5'd0,
                                  5'd8, 5'd0, 5'd5, 5'd31, 5'd4};
  logic [31:0] mx_imm  [0:12] = '{32'hABCD0000, 32'h0000F0F0, 32'hFFFF8000, 32'hFFFF8000,
                                  32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFE,
                                  32'h0, 32'h0000FFFF};
  logic [31:0] ill_inst [0:2] = '{32'hFC000000, 32'h00000001, 32'h04020000};

  initial begin
    MRST_N = 1'b0; in_valid = 1'b0; in_inst = 32'd0; out_ready = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_rlabel", {30'd0, ReadLabel}, 32'd1);
    chk("reset_wlabel", {30'd0, WriteLabel}, 32'd1);
    chk("reset_rd", {27'd0, RDaddr}, 32'd0);
    chk("reset_imm", Imm, 32'd0);
    chk("reset_trap", {31'd0, illegal_trap}, 32'd0);
    @(negedge CLK);
    MRST_N = 1'b1;
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

    send(32'h2128FFFF, 5'd8, 32'hFFFFFFFF, 1'b0, 1'b0);
    idle(2);
    chk("addi_drop_valid", {31'd0, out_valid}, 32'd0);

    // SETR held by backpressure: label must not move until the retire edge.
    out_ready = 1'b0;
    send(32'h20020003, 5'd0, 32'h00000003, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      in_valid = 1'b0;
      #1;
      chk("setr_held_valid", {31'd0, out_valid}, 32'd1);
      chk("setr_held_wlabel", {30'd0, WriteLabel}, 32'd1);
    end
    @(negedge CLK);
    out_ready = 1'b1;
    @(negedge CLK);
    #1;
    chk("setr_wlabel", {30'd0, WriteLabel}, 32'd3);
    chk("setr_rlabel", {30'd0, ReadLabel}, 32'd1);

    idle(3);
    send(32'h20010002, 5'd0, 32'h00000002, 1'b1, 1'b0);
    idle(3);
    chk("setr_r_rlabel", {30'd0, ReadLabel}, 32'd2);
    chk("setr_r_wlabel", {30'd0, WriteLabel}, 32'd3);
    send(32'h20000000, 5'd0, 32'h00000000, 1'b1, 1'b0);
    idle(3);
    chk("setr_b_rlabel", {30'd0, ReadLabel}, 32'd0);
    chk("setr_b_wlabel", {30'd0, WriteLabel}, 32'd0);
    send(32'h20020004, 5'd2, 32'h00000004, 1'b0, 1'b0);
    idle(3);
    chk("nearmiss_wlabel", {30'd0, WriteLabel}, 32'd0);

    // Syscall stall: in_ready low for exactly two cycles after the accept.
    idle(2);
    send(32'h0000000C, 5'd0, 32'h0, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge CLK);
      in_valid = 1'b0;
      #1;
      chk("stall_in_ready", {31'd0, in_ready}, (i < 3) ? 32'd0 : 32'd1);
    end

    idle(3);
    max_run = 0;
    for (int i = 0; i < 5; i++)
      send({6'h00, 5'(i), 5'(i + 1), 5'(i + 10), 5'h00, 6'h20}, 5'(i + 10), 32'h0, 1'b0, 1'b0);
    idle(4);
    chk("b2b_run", max_run, 32'd5);

    bp_en = 1'b1;
    for (int i = 0; i < 13; i++) send(mx_inst[i], mx_rd[i], mx_imm[i], 1'b0, 1'b0);
    bp_en = 1'b0;
    out_ready = 1'b1;
    idle(6);
    chk("drained", q.size(), 32'd0);

    for (int i = 0; i < 3; i++) begin
      send(ill_inst[i], 5'd0, 32'h0, 1'b0, 1'b1);
      idle(3);
`ifdef RD_ILLEGAL_TRAP_EN
      chk("trap_set", {31'd0, illegal_trap}, 32'd1);
      chk("trap_in_ready", {31'd0, in_ready}, 32'd0);
      idle(2);
      chk("trap_sticky", {31'd0, in_ready}, 32'd0);
      pulse_reset();
      chk("trap_cleared", {31'd0, illegal_trap}, 32'd0);
      chk("trap_rst_ready", {31'd0, in_ready}, 32'd1);
`else
      chk("notrap", {31'd0, illegal_trap}, 32'd0);
      chk("notrap_ready", {31'd0, in_ready}, 32'd1);
`endif
    end
    pulse_reset();
    chk("final_wlabel", {30'd0, WriteLabel}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

endmodule
